pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_slice.sv | 26 ++
 rtl/pipe_stage_reg.sv | 81 ++++++++
 tb/tb_pipe_stage_reg.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the stage payload record for the writeback pipeline register.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int CNT_W_DEF  = 16;

    // "do" is a reserved word, so the memory-data field is named mdo.
    typedef struct packed {
        logic                  valid;
        logic                  wreg;
        logic                  m2reg;
        logic [REG_W_DEF-1:0]  dest;
        logic [DATA_W_DEF-1:0] r;
        logic [DATA_W_DEF-1:0] mdo;
    } stage_t;

endpackage

// File: rtl/pipe_stage_slice.sv
// One pipeline stage: load, hold on stall, squash to a bubble on flush, async clear on rst.
module pipe_stage_slice #(
    parameter type stage_t = pipe_pkg::stage_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  stage_t d,
    output stage_t q
);

    // NOTE: non-blocking assignments keep every stage sampling its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload is cleared too, so out_wdata reads 0 straight out of reset.
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.wreg  <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Writeback pipeline register: DEPTH stall/flush-capable stages, write qualification,
// writeback mux and a saturating count of retired bubbles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_wreg,
    input  logic              in_m2reg,
    input  logic [REG_W-1:0]  in_dest,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_do,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic              out_wreg,
    output logic              out_m2reg,
    output logic [REG_W-1:0]  out_dest,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_do,
    output logic [DATA_W-1:0] out_wdata,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic              m2reg;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] mdo;
    } stage_w_t;

    stage_w_t head;
    stage_w_t stg [DEPTH];
    stage_w_t last;

    assign head = '{valid: in_valid, wreg: in_wreg, m2reg: in_m2reg,
                    dest: in_dest, r: in_r, mdo: in_do};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_stage_slice #(.stage_t(stage_w_t)) u_slice (
                .clk(clk), .rst(rst), .stall(stall), .flush(flush),
                .d(head), .q(stg[0])
            );
        end else begin : g_next
            pipe_stage_slice #(.stage_t(stage_w_t)) u_slice (
                .clk(clk), .rst(rst), .stall(stall), .flush(flush),
                .d(stg[k-1]), .q(stg[k])
            );
        end
    end

    assign last      = stg[DEPTH-1];
    assign out_valid = last.valid;
    assign out_m2reg = last.m2reg;
    assign out_dest  = last.dest;
    assign out_r     = last.r;
    assign out_do    = last.mdo;

    // Register 0 is hard-wired, so a write aimed at it is never issued.
    assign out_wreg  = last.valid && last.wreg && (last.dest != '0);
    assign out_wdata = last.m2reg ? last.mdo : last.r;

    // Counts edges where the last stage retires a bubble; flush does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!stall && !last.valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three pipe_stage_reg instances (DEPTH 1, 2, 3) share stimulus and are
// compared against a queue-based model, a hand-computed vector table and directed sequences.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_wreg, in_m2reg, stall, flush;
    logic [4:0]  in_dest;
    logic [31:0] in_r, in_do;

    logic        ov [3];
    logic        ow [3];
    logic        om [3];
    logic [4:0]  odest [3];
    logic [31:0] oor [3];
    logic [31:0] odo [3];
    logic [31:0] owd [3];
    logic [15:0] cnt1, cnt2;
    logic [3:0]  cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_wreg(in_wreg), .in_m2reg(in_m2reg),
        .in_dest(in_dest), .in_r(in_r), .in_do(in_do), .stall(stall), .flush(flush),
        .out_valid(ov[0]), .out_wreg(ow[0]), .out_m2reg(om[0]), .out_dest(odest[0]),
        .out_r(oor[0]), .out_do(odo[0]), .out_wdata(owd[0]), .bubble_cnt(cnt1)
    );

    pipe_stage_reg #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_wreg(in_wreg), .in_m2reg(in_m2reg),
        .in_dest(in_dest), .in_r(in_r), .in_do(in_do), .stall(stall), .flush(flush),
        .out_valid(ov[1]), .out_wreg(ow[1]), .out_m2reg(om[1]), .out_dest(odest[1]),
        .out_r(oor[1]), .out_do(odo[1]), .out_wdata(owd[1]), .bubble_cnt(cnt2)
    );

    pipe_stage_reg #(.DEPTH(3), .CNT_W(4)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_wreg(in_wreg), .in_m2reg(in_m2reg),
        .in_dest(in_dest), .in_r(in_r), .in_do(in_do), .stall(stall), .flush(flush),
        .out_valid(ov[2]), .out_wreg(ow[2]), .out_m2reg(om[2]), .out_dest(odest[2]),
        .out_r(oor[2]), .out_do(odo[2]), .out_wdata(owd[2]), .bubble_cnt(cnt3)
    );

    // ---------------- reference model: one queue of in-flight instructions per DUT
    typedef struct {
        logic        valid;
        logic        wreg;
        logic        m2reg;
        logic [4:0]  dest;
        logic [31:0] r;
        logic [31:0] d;
    } instr_t;

    instr_t      mq [3][$];
    int unsigned mcnt [3];
    int unsigned cmax [3] = '{65535, 65535, 15};

    function automatic instr_t cur_in();
        instr_t t;
        t.valid = in_valid; t.wreg = in_wreg; t.m2reg = in_m2reg;
        t.dest  = in_dest;  t.r    = in_r;    t.d     = in_do;
        return t;
    endfunction

    task automatic model_reset();
        instr_t z;
        z = '{valid: 1'b0, wreg: 1'b0, m2reg: 1'b0, dest: 5'd0, r: 32'd0, d: 32'd0};
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            for (int k = 0; k <= i; k++) mq[i].push_back(z);
            mcnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        instr_t last;
        instr_t t;
        for (int i = 0; i < 3; i++) begin
            last = mq[i][mq[i].size()-1];
            if (!stall && !last.valid && mcnt[i] < cmax[i]) mcnt[i]++;
            if (flush) begin
                for (int k = 0; k < mq[i].size(); k++) begin
                    t = mq[i][k];
                    t.valid = 1'b0;
                    t.wreg  = 1'b0;
                    mq[i][k] = t;
                end
            end else if (!stall) begin
                mq[i].push_front(cur_in());
                void'(mq[i].pop_back());
            end
        end
    endtask

    function automatic logic [63:0] cnt_of(int i);
        case (i)
            0:       return 64'(cnt1);
            1:       return 64'(cnt2);
            default: return 64'(cnt3);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        instr_t e;
        for (int i = 0; i < 3; i++) begin
            e = mq[i][mq[i].size()-1];
            check($sformatf("d%0d out_valid", i+1), 64'(ov[i]), 64'(e.valid));
            check($sformatf("d%0d out_wreg", i+1), 64'(ow[i]),
                  64'(e.valid && e.wreg && (e.dest != 5'd0)));
            check($sformatf("d%0d out_m2reg", i+1), 64'(om[i]), 64'(e.m2reg));
            check($sformatf("d%0d out_dest", i+1), 64'(odest[i]), 64'(e.dest));
            check($sformatf("d%0d out_r", i+1), 64'(oor[i]), 64'(e.r));
            check($sformatf("d%0d out_do", i+1), 64'(odo[i]), 64'(e.d));
            check($sformatf("d%0d out_wdata", i+1), 64'(owd[i]), 64'(e.m2reg ? e.d : e.r));
            check($sformatf("d%0d bubble_cnt", i+1), cnt_of(i), 64'(mcnt[i]));
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare #1 after the edge.
    task automatic step(input logic s, input logic f, input logic v, input logic w,
                        input logic m, input logic [4:0] dst, input logic [31:0] r,
                        input logic [31:0] d);
        stall = s; flush = f; in_valid = v; in_wreg = w; in_m2reg = m;
        in_dest = dst; in_r = r; in_do = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // Asserts rst between edges, checks every output is already 0, then releases it.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst d%0d out_valid", i+1), 64'(ov[i]), 64'd0);
            check($sformatf("rst d%0d out_wreg", i+1), 64'(ow[i]), 64'd0);
            check($sformatf("rst d%0d out_wdata", i+1), 64'(owd[i]), 64'd0);
            check($sformatf("rst d%0d out_dest", i+1), 64'(odest[i]), 64'd0);
            check($sformatf("rst d%0d bubble_cnt", i+1), cnt_of(i), 64'd0);
        end
        model_reset();
        #2 rst = 1'b0;
    endtask

    // ---------------- vector table for the DEPTH=1 instance (expected values hand-derived)
    typedef struct {
        logic        s, f, v, w, m;
        logic [4:0]  dst;
        logic [31:0] r, d;
        logic        e_valid, e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [31:0] prev_cnt;

        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1234,     32'h0,        1'b1, 1'b1, 32'h1234};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hAAAA,     32'h0,        1'b1, 1'b0, 32'hAAAA};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1,        32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h5555,     32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h7777,     32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h42,       32'h0,        1'b0, 1'b0, 32'h42};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h99,       32'h0,        1'b1, 1'b0, 32'h99};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h1,        32'h0,        1'b0, 1'b0, 32'h99};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_wreg = 1'b0;
        in_m2reg = 1'b0; in_dest = 5'd0; in_r = 32'd0; in_do = 32'd0;
        model_reset();
        @(posedge clk);
        #1;
        compare_model();
        rst = 1'b0;

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            step(vt[i].s, vt[i].f, vt[i].v, vt[i].w, vt[i].m, vt[i].dst, vt[i].r, vt[i].d);
            check($sformatf("vec%0d d1 out_valid", i), 64'(ov[0]), 64'(vt[i].e_valid));
            check($sformatf("vec%0d d1 out_wreg", i), 64'(ow[0]), 64'(vt[i].e_wreg));
            check($sformatf("vec%0d d1 out_wdata", i), 64'(owd[0]), 64'(vt[i].e_wdata));
        end

        // DEPTH=2 latency: visible after the second edge, not the first.
        async_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
        check("lat d2 early out_valid", 64'(ov[1]), 64'd0);
        idle();
        check("lat d2 out_valid", 64'(ov[1]), 64'd1);
        check("lat d2 out_wreg", 64'(ow[1]), 64'd1);
        check("lat d2 out_wdata", 64'(owd[1]), 64'h1234);

        // DEPTH=3 stream with a 2-cycle stall mid-stream.
        async_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 32'hA, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'hB, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'hC, 32'h0);
        check("stream d3 first", 64'(oor[2]), 64'hA);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'hEE, 32'h0);
            check("stall d3 frozen r", 64'(oor[2]), 64'hA);
            check("stall d3 frozen valid", 64'(ov[2]), 64'd1);
        end
        idle();
        check("stream d3 second", 64'(oor[2]), 64'hB);
        idle();
        check("stream d3 third", 64'(oor[2]), 64'hC);
        check("stream d3 third valid", 64'(ov[2]), 64'd1);
        idle();
        check("stream d3 drained", 64'(ov[2]), 64'd0);

        // Flush beats stall with three valid stages; bubbles then count up.
        async_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'(k+1), 32'(k), 32'h0);
        check("pre-flush d3 valid", 64'(ov[2]), 64'd1);
        check("pre-flush d3 cnt", 64'(cnt3), 64'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 32'h0);
        check("flush d3 out_valid", 64'(ov[2]), 64'd0);
        check("flush d3 out_wreg", 64'(ow[2]), 64'd0);
        check("flush d3 cnt held", 64'(cnt3), 64'd3);
        prev_cnt = 32'(cnt3);
        for (int k = 0; k < 2; k++) begin
            idle();
            check("drain d3 out_valid", 64'(ov[2]), 64'd0);
            check("drain d3 cnt step", 64'(cnt3), 64'(prev_cnt + 1));
            prev_cnt = 32'(cnt3);
        end

        // Reset with data in flight, then counter saturation on the CNT_W=4 instance.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1, 32'hCAFE);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h2, 32'h0);
        async_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            check("post-rst no ghost d3", 64'(ov[2]), 64'd0);
            check("post-rst no ghost d2", 64'(ov[1]), 64'd0);
        end
        repeat (15) idle();
        check("sat d3 cnt", 64'(cnt3), 64'hF);
        idle();
        check("sat d3 cnt hold", 64'(cnt3), 64'hF);

        // Randomized traffic against the model.
        async_reset();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 31)), $urandom, $urandom);
            if (n == 200) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
